aes128_round_ctrl: RTL and testbench

- Iterative AES-128 encryption controller.
- Sequences the existing combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over a single 128-bit state register, one round per clock.
- Generates round keys on the fly with one key-schedule step per cycle.
- Sits between the host block interface (valid/ready) and the round-function blocks; it is the only owner of the state and round-key registers.

---
 rtl/aes128_round_ctrl_if.sv | 23 ++
 rtl/aes128_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aes128_round_ctrl_if.sv
// Host-side block interface of the iterative AES-128 controller.
// Input side: in_valid/in_ready handshake carrying plaintext and cipher key.
// Output side: out_valid/out_ready handshake carrying the ciphertext.
// Byte k of each 128-bit word is at bits [8k+:8], column-major.
interface aes128_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] pt_i;
    logic [0:127] key_i;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] ct_o;

    modport master (
        output in_valid, pt_i, key_i, out_ready,
        input  in_ready, out_valid, ct_o
    );

    modport slave (
        input  in_valid, pt_i, key_i, out_ready,
        output in_ready, out_valid, ct_o
    );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a single
// state register, with the round key expanded on the fly from the key register.
// Optional debug taps (round counter, live state) are enabled by defining
// the macro AES_ROUND_TAP_EN.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | rounds 1..9 (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// LAST  | round 10 (no MixColumns)
// HOLD  | ciphertext presented until out_ready
module aes128_round_ctrl #(
    parameter int NR      = 10,
    parameter bit ZEROIZE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    aes128_round_ctrl_if.slave  bus
`ifdef AES_ROUND_TAP_EN
    ,
    output logic [3:0]          round_o,
    output logic [0:127]        st_tap_o
`endif
);

    if (NR != 10) begin : g_bad_nr
        $error("aes128_round_ctrl supports only NR=10");
    end

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, LAST, HOLD} state_t;

    state_t       state_q, state_nx;
    logic [0:127] st_q, st_nx;
    logic [0:127] key_q, key_nx;
    logic [3:0]   round_q, round_nx;
    logic [7:0]   rcon_q, rcon_nx;
    logic [0:127] sr_w, mc_w, kx_w;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows: row r of column c comes from column c+r.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[8*(4*c+rw) +: 8] = sbox(s[8*(4*((c+rw)%4)+rw) +: 8]);
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            r[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // One key-schedule step; word byte 0 sits in the word's top byte.
    function automatic logic [0:127] key_expand(input logic [0:127] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[0  +: 32];
        w1 = k[32 +: 32];
        w2 = k[64 +: 32];
        w3 = k[96 +: 32];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign sr_w = sub_shift(st_q);
    assign mc_w = mix_columns(sr_w);
    assign kx_w = key_expand(key_q, rcon_q);

    // Next-state and next register values; a load from HOLD is identical to one from IDLE.
    always_comb begin
        state_nx = state_q;
        st_nx    = st_q;
        key_nx   = key_q;
        round_nx = round_q;
        rcon_nx  = rcon_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_nx    = bus.pt_i ^ bus.key_i;
                    key_nx   = bus.key_i;
                    round_nx = 4'd1;
                    rcon_nx  = 8'h01;
                    state_nx = RUN;
                end
            end
            RUN: begin
                st_nx    = mc_w ^ kx_w;
                key_nx   = kx_w;
                rcon_nx  = xtime(rcon_q);
                round_nx = round_q + 4'd1;
                if (round_q == 4'd9) state_nx = LAST;
            end
            LAST: begin
                st_nx    = sr_w ^ kx_w;
                key_nx   = kx_w;
                round_nx = 4'd0;
                state_nx = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        st_nx    = bus.pt_i ^ bus.key_i;
                        key_nx   = bus.key_i;
                        round_nx = 4'd1;
                        rcon_nx  = 8'h01;
                        state_nx = RUN;
                    end else begin
                        state_nx = IDLE;
                        if (ZEROIZE) begin
                            st_nx  = '0;
                            key_nx = '0;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, data and key registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_nx;
            st_q    <= st_nx;
            key_q   <= key_nx;
            round_q <= round_nx;
            rcon_q  <= rcon_nx;
        end
    end

    // Outputs are forced quiet while reset is asserted so the reset cycle itself is clean.
    assign bus.in_ready  = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & bus.out_ready));
    assign bus.out_valid = rst_n & (state_q == HOLD);
    assign bus.ct_o      = (rst_n && (state_q == HOLD || !ZEROIZE)) ? st_q : '0;

`ifdef AES_ROUND_TAP_EN
    assign round_o  = round_q;
    assign st_tap_o = st_q;
`endif

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 vectors.
module tb_aes128_round_ctrl;

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes128_round_ctrl_if bus();

`ifdef AES_ROUND_TAP_EN
    logic [3:0]   round_o;
    logic [0:127] st_tap_o;
`endif

    aes128_round_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef AES_ROUND_TAP_EN
        ,
        .round_o  (round_o),
        .st_tap_o (st_tap_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a block and let it be accepted at the next edge (T0).
    task automatic send(input logic [0:127] pt, input logic [0:127] key, input string tag);
        bus.pt_i     = pt;
        bus.key_i    = key;
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // From just after T0: no output through T0+9, result right after T0+10.
    task automatic expect_ct(input logic [0:127] exp, input bit scramble, input string tag);
        for (int i = 0; i < 9; i++) begin
            if (scramble) begin
                bus.pt_i  = {$urandom, $urandom, $urandom, $urandom};
                bus.key_i = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        chk({tag, "_early_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_busy_ready"}, bus.in_ready, 1'b0);
        tick();
        chk({tag, "_out_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_ct"}, bus.ct_o, exp);
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ret_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_ret_ct_zero"}, bus.ct_o, 128'h0);
        chk({tag, "_ret_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.pt_i      = '0;
        bus.key_i     = '0;
        #1;
        chk("rst_cycle_in_ready", bus.in_ready, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ct", bus.ct_o, 128'h0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("idle_ct_zero", bus.ct_o, 128'h0);

        // FIPS-197 C.1 with inputs scrambled during the run
        send(C1_PT, C1_KEY, "c1");
`ifdef AES_ROUND_TAP_EN
        chk("c1_tap_r1_start", st_tap_o, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("c1_round1", round_o, 4'd1);
`endif
        expect_ct(C1_CT, 1'b1, "c1");
`ifdef AES_ROUND_TAP_EN
        chk("c1_hold_round", round_o, 4'd0);
`endif
        chk("c1_hold_ready", bus.in_ready, 1'b0);
        retire("c1");

        // FIPS-197 Appendix B
        send(B_PT, B_KEY, "appb");
        expect_ct(B_CT, 1'b0, "appb");
        retire("appb");

        // All-zero vector, then a 20-cycle stall with in_valid toggling
        send('0, '0, "zero");
        expect_ct(Z_CT, 1'b0, "zero");
        bus.pt_i  = C1_PT;
        bus.key_i = C1_KEY;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            tick();
            chk("stall_ct", bus.ct_o, Z_CT);
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_in_ready", bus.in_ready, 1'b0);
        end

        // Retire and accept at the same edge
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", bus.in_ready, 1'b1);
        chk("b2b_ct_before", bus.ct_o, Z_CT);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_retired", bus.out_valid, 1'b0);
        chk("b2b_busy", bus.in_ready, 1'b0);
        expect_ct(C1_CT, 1'b0, "b2b");
        retire("b2b");

        // Reset at T0+5 abandons the block
        send(B_PT, B_KEY, "abort");
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_valid", bus.out_valid, 1'b0);
        chk("abort_ct", bus.ct_o, 128'h0);
        chk("abort_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_output", bus.out_valid, 1'b0);
        end
        send(B_PT, B_KEY, "fresh");
        expect_ct(B_CT, 1'b0, "fresh");
        retire("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
